// File: rtl/usb_tx_packet.sv
// usb_tx_packet: frames a USB low-speed packet (PID, payload, CRC16) into a byte-serial sender.
// Optional feature macro USB_TX_CRC16_EN: when defined, CRC16 is generated and appended to data packets.
module usb_tx_packet #(
  parameter int MAX_LEN = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] pid,
  input  logic [3:0] len,
  output logic       busy,
  output logic       done,
  output logic [2:0] buf_addr,
  input  logic [7:0] buf_data,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic       tx_den
);

  localparam logic [3:0] MAX_LEN_C = 4'(MAX_LEN);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    FETCH   = 4'd1,
    SYNC    = 4'd2,
    PAYLOAD = 4'd3,
`ifdef USB_TX_CRC16_EN
    CRC_LO  = 4'd4,
    CRC_HI  = 4'd5,
`endif
    LAST    = 4'd6,
    EOP     = 4'd7,
    DONE    = 4'd8
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [7:0]  next_byte_r;
  logic        den_q_r;
  logic        is_data_r;
  logic [3:0]  len_r;
  logic [3:0]  cnt_r;
  logic        fetch_cnt_r;
  logic        busy_s;
  logic        done_s;
  logic        tx_valid_s;

`ifdef USB_TX_CRC16_EN
  logic [15:0] crc_r;
  logic [15:0] crc_next_s;

  // Reflected CRC16 (0xA001) advanced by one byte, LSB first.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc_in, input logic [7:0] data_in);
    logic [15:0] c;
    c = crc_in ^ {8'h00, data_in};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) begin
        c = (c >> 1) ^ 16'hA001;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

  assign crc_next_s = crc16_step(crc_r, tx_data);
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = FETCH;
        end else begin
          state_next_s = IDLE;
        end
      end
      FETCH: begin
        if (fetch_cnt_r) begin
          state_next_s = SYNC;
        end else begin
          state_next_s = FETCH;
        end
      end
      SYNC: begin
        if (!tx_ready) begin
          state_next_s = SYNC;
        end else if (!is_data_r) begin
          state_next_s = LAST;
        end else if (len_r != 4'd0) begin
          state_next_s = PAYLOAD;
        end else begin
`ifdef USB_TX_CRC16_EN
          state_next_s = CRC_LO;
`else
          state_next_s = LAST;
`endif
        end
      end
      PAYLOAD: begin
        if (tx_ready && (cnt_r == len_r)) begin
`ifdef USB_TX_CRC16_EN
          state_next_s = CRC_LO;
`else
          state_next_s = LAST;
`endif
        end else begin
          state_next_s = PAYLOAD;
        end
      end
`ifdef USB_TX_CRC16_EN
      CRC_LO: begin
        if (tx_ready) begin
          state_next_s = CRC_HI;
        end else begin
          state_next_s = CRC_LO;
        end
      end
      CRC_HI: begin
        if (tx_ready) begin
          state_next_s = LAST;
        end else begin
          state_next_s = CRC_HI;
        end
      end
`endif
      LAST: begin
        if (tx_ready) begin
          state_next_s = EOP;
        end else begin
          state_next_s = LAST;
        end
      end
      EOP: begin
        if (den_q_r && !tx_den) begin
          state_next_s = DONE;
        end else begin
          state_next_s = EOP;
        end
      end
      DONE: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so the registered outputs align with it.
  always_comb begin
    busy_s     = (state_next_s != IDLE);
    done_s     = (state_next_s == DONE);
    tx_valid_s = 1'b0;
    case (state_next_s)
      SYNC:    tx_valid_s = 1'b1;
      PAYLOAD: tx_valid_s = 1'b1;
`ifdef USB_TX_CRC16_EN
      CRC_LO:  tx_valid_s = 1'b1;
      CRC_HI:  tx_valid_s = 1'b1;
`endif
      LAST:    tx_valid_s = 1'b1;
      default: tx_valid_s = 1'b0;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      tx_valid <= 1'b0;
    end else begin
      busy     <= busy_s;
      done     <= done_s;
      tx_valid <= tx_valid_s;
    end
  end

  // Byte datapath: next_byte_r tracks buf_data continuously; tx_ready spacing gives it time to settle.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_data     <= 8'h00;
      buf_addr    <= 3'd0;
      next_byte_r <= 8'h00;
      den_q_r     <= 1'b0;
      is_data_r   <= 1'b0;
      len_r       <= 4'd0;
      cnt_r       <= 4'd0;
      fetch_cnt_r <= 1'b0;
`ifdef USB_TX_CRC16_EN
      crc_r       <= 16'hFFFF;
`endif
    end else begin
      next_byte_r <= buf_data;
      den_q_r     <= tx_den;
      case (state_r)
        IDLE: begin
          if (start) begin
            is_data_r   <= (pid[2:0] == 3'b011);
            len_r       <= (len > MAX_LEN_C) ? MAX_LEN_C : len;
            cnt_r       <= 4'd0;
            fetch_cnt_r <= 1'b0;
            buf_addr    <= 3'd0;
            tx_data     <= {~pid, pid};
`ifdef USB_TX_CRC16_EN
            crc_r       <= 16'hFFFF;
`endif
          end
        end
        FETCH: begin
          fetch_cnt_r <= 1'b1;
        end
        SYNC: begin
          if (tx_ready && is_data_r) begin
            if (len_r != 4'd0) begin
              tx_data  <= next_byte_r;
              cnt_r    <= 4'd1;
              buf_addr <= buf_addr + 3'd1;
            end
`ifdef USB_TX_CRC16_EN
            else begin
              tx_data <= ~crc_r[7:0];
            end
`endif
          end
        end
        PAYLOAD: begin
          if (tx_ready) begin
`ifdef USB_TX_CRC16_EN
            crc_r <= crc_next_s;
`endif
            if (cnt_r != len_r) begin
              tx_data  <= next_byte_r;
              cnt_r    <= cnt_r + 4'd1;
              buf_addr <= buf_addr + 3'd1;
            end
`ifdef USB_TX_CRC16_EN
            else begin
              tx_data <= ~crc_next_s[7:0];
            end
`endif
          end
        end
`ifdef USB_TX_CRC16_EN
        CRC_LO: begin
          if (tx_ready) begin
            tx_data <= ~crc_r[15:8];
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx_packet.sv
// Self-checking bench for usb_tx_packet: directed vectors plus randomized packets against a byte-list model.
module tb_usb_tx_packet;
  localparam int MAX_LEN = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] pid;
  logic [3:0] len;
  logic       busy;
  logic       done;
  logic [2:0] buf_addr;
  logic [7:0] buf_data;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_den;

  int checks = 0;
  int failures = 0;
  logic [7:0] mem [0:7];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  usb_tx_packet #(.MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .reset(reset), .start(start), .pid(pid), .len(len),
    .busy(busy), .done(done), .buf_addr(buf_addr), .buf_data(buf_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_den(tx_den)
  );

  always #5 clk = ~clk;

  // Payload buffer with one-cycle read latency.
  always @(posedge clk) buf_data <= mem[buf_addr];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Transmitted CRC: MSB-first division by 0x8005 over LSB-first bits, reflected and complemented.
  function automatic logic [15:0] usb_crc16(input int n);
    logic [15:0] c;
    logic [15:0] r;
    logic fb;
    c = 16'hFFFF;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 8; i++) begin
        fb = c[15] ^ mem[k][i];
        c = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h8005;
      end
    end
    for (int i = 0; i < 16; i++) r[i] = c[15-i];
    return ~r;
  endfunction

  task automatic build_expected(input logic [3:0] p, input logic [3:0] l);
    int n;
    logic [15:0] crc;
    exp_q.delete();
    exp_q.push_back({~p, p});
    if (p == 4'b0011 || p == 4'b1011) begin
      n = (int'(l) > MAX_LEN) ? MAX_LEN : int'(l);
      for (int k = 0; k < n; k++) exp_q.push_back(mem[k]);
`ifdef USB_TX_CRC16_EN
      crc = usb_crc16(n);
      exp_q.push_back(crc[7:0]);
      exp_q.push_back(crc[15:8]);
`else
      crc = 16'h0000;
`endif
    end
  endtask

  task automatic cmp_q(input string tag);
    int n;
    check({tag, " count"}, 16'(got_q.size()), 16'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s byte%0d", tag, i), {8'h00, got_q[i]}, {8'h00, exp_q[i]});
  endtask

  // Drive one packet with a sender model; abort_after>0 asserts reset after that many tx_ready pulses.
  task automatic run_packet(input logic [3:0] p, input logic [3:0] l, input bit extra_start,
                            input int abort_after, input string tag);
    int gap, since_ready, den_cnt, nready;
    bit eop, done_seen, ready_prev, fell_early, busy_bad, valid_seen, valid_was, aborted;
    build_expected(p, l);
    got_q.delete();
    @(negedge clk);
    start = 1'b1; pid = p; len = l;
    @(negedge clk);
    start = 1'b0; pid = 4'($urandom); len = 4'($urandom);
    check({tag, " busy_after_start"}, {15'd0, busy}, 16'd1);
    gap = $urandom_range(3, 6); since_ready = 0; den_cnt = 0; nready = 0;
    eop = 0; done_seen = 0; ready_prev = 0; fell_early = 0; busy_bad = 0;
    valid_seen = 0; valid_was = 0; aborted = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (abort_after != 0 && ready_prev && nready == abort_after) begin
        reset = 1'b1; tx_ready = 1'b0; aborted = 1; break;
      end
      if (done) begin
        done_seen = 1; break;
      end
      if (!busy) busy_bad = 1;
      if (tx_valid) begin valid_seen = 1; tx_den = 1'b1; end
      if (ready_prev && !tx_valid && !eop) begin
        eop = 1; void'(got_q.pop_back()); den_cnt = $urandom_range(2, 5);
      end else if (valid_was && !tx_valid && !eop) begin
        fell_early = 1;
      end
      valid_was = tx_valid;
      tx_ready = 1'b0; ready_prev = 0;
      if (eop) begin
        tx_ready = 1'($urandom);
        if (den_cnt == 0) tx_den = 1'b0; else den_cnt--;
      end else if (tx_valid) begin
        if (since_ready >= gap) begin
          tx_ready = 1'b1; ready_prev = 1; got_q.push_back(tx_data);
          since_ready = 0; gap = $urandom_range(3, 6); nready++;
          if (extra_start && nready == 2) begin start = 1'b1; pid = 4'b0010; len = 4'd3; end
        end else begin
          since_ready++;
        end
      end else if (!valid_seen) begin
        tx_ready = 1'($urandom);
      end
      @(negedge clk);
      start = 1'b0;
    end
    tx_ready = 1'b0;
    if (aborted) begin
      @(negedge clk);
      check({tag, " rst_valid"}, {15'd0, tx_valid}, 16'd0);
      check({tag, " rst_busy"}, {15'd0, busy}, 16'd0);
      check({tag, " rst_tx_data"}, {8'h00, tx_data}, 16'h0000);
      check({tag, " rst_addr"}, {13'd0, buf_addr}, 16'd0);
      reset = 1'b0; tx_den = 1'b0; done_seen = 0;
      repeat (20) begin
        @(negedge clk);
        if (done) done_seen = 1;
      end
      check({tag, " no_done_after_abort"}, {15'd0, done_seen}, 16'd0);
    end else begin
      tx_den = 1'b0;
      check({tag, " done_seen"}, {15'd0, done_seen}, 16'd1);
      check({tag, " valid_fell_early"}, {15'd0, fell_early}, 16'd0);
      check({tag, " busy_held"}, {15'd0, busy_bad}, 16'd0);
      cmp_q(tag);
      @(negedge clk);
      check({tag, " done_one_cycle"}, {15'd0, done}, 16'd0);
      check({tag, " busy_idle"}, {15'd0, busy}, 16'd0);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pid = 4'd0; len = 4'd0; tx_ready = 1'b0; tx_den = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("reset tx_valid", {15'd0, tx_valid}, 16'd0);
    check("reset busy", {15'd0, busy}, 16'd0);
    check("reset done", {15'd0, done}, 16'd0);
    check("reset tx_data", {8'h00, tx_data}, 16'h0000);
    check("reset buf_addr", {13'd0, buf_addr}, 16'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    run_packet(4'b0010, 4'd5, 1'b0, 0, "ack");
    exp_q = '{8'hD2};
    cmp_q("ack const");

    run_packet(4'b0011, 4'd0, 1'b0, 0, "data0_len0");
`ifdef USB_TX_CRC16_EN
    exp_q = '{8'hC3, 8'h00, 8'h00};
`else
    exp_q = '{8'hC3};
`endif
    cmp_q("data0_len0 const");

    mem[0] = 8'h00;
    run_packet(4'b1011, 4'd1, 1'b0, 0, "data1_len1");
`ifdef USB_TX_CRC16_EN
    exp_q = '{8'h4B, 8'h00, 8'h40, 8'hBF};
`else
    exp_q = '{8'h4B, 8'h00};
`endif
    cmp_q("data1_len1 const");

    for (int i = 0; i < 8; i++) mem[i] = 8'h10 + 8'(i);
    run_packet(4'b0011, 4'd12, 1'b1, 0, "clamp");
    check("clamp payload count", 16'(got_q.size()),
`ifdef USB_TX_CRC16_EN
          16'd11);
`else
          16'd9);
`endif

    for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
    run_packet(4'b1011, 4'd8, 1'b0, 3, "abort");
    repeat (2) @(negedge clk);
    run_packet(4'b0010, 4'd0, 1'b0, 0, "ack_after_abort");
    exp_q = '{8'hD2};
    cmp_q("ack_after_abort const");

    for (int t = 0; t < 12; t++) begin
      logic [3:0] rp;
      for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
      rp = 4'($urandom);
      if ($urandom_range(0, 2) != 0) rp = ($urandom_range(0, 1) != 0) ? 4'b0011 : 4'b1011;
      run_packet(rp, 4'($urandom), 1'($urandom), 0, $sformatf("rand%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
